// File: rtl/fifo_bank_if.sv
// rtl/fifo_bank_if.sv - push/pop command and status bundle for fifo_bank
interface fifo_bank_if #(
  parameter int DATA_WIDTH = 10
) ();
  logic                  push;
  logic [1:0]            push_id;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [1:0]            pop_id;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic [3:0]            empty;
  logic [3:0]            full;
  logic [3:0]            almost_full;
  logic                  error;

  modport master (
    output push, push_id, data_in, read, pop_id,
    input  data_out, valid, empty, full, almost_full, error
  );

  modport slave (
    input  push, push_id, data_in, read, pop_id,
    output data_out, valid, empty, full, almost_full, error
  );
endinterface

// File: rtl/fifo_bank.sv
// rtl/fifo_bank.sv - four independent FIFOs with registered pop output and error pulse
module fifo_bank #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input logic        clk,
  input logic        reset,
  fifo_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [4][DEPTH];
  logic [AW-1:0]         wr_ptr [4];
  logic [AW-1:0]         rd_ptr [4];
  logic [AW:0]           count  [4];

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  error_q;
  logic                  pop_ok;
  logic                  push_ok;
  logic [3:0]            empty_c;
  logic [3:0]            full_c;
  logic [3:0]            af_c;

  always_comb begin
    pop_ok  = bus.read && (count[bus.pop_id] != '0);
    // A full queue still accepts a push when the same edge pops it.
    push_ok = bus.push && ((count[bus.push_id] != (AW+1)'(DEPTH)) ||
                           (pop_ok && (bus.pop_id == bus.push_id)));
  end

  always_comb begin
    empty_c = '0;
    full_c  = '0;
    af_c    = '0;
    for (int q = 0; q < 4; q++) begin
      empty_c[q] = (count[q] == '0);
      full_c[q]  = (count[q] == (AW+1)'(DEPTH));
      af_c[q]    = (count[q] >= (AW+1)'(AF_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[bus.push_id][wr_ptr[bus.push_id]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int q = 0; q < 4; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        count[q]  <= '0;
      end
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      for (int q = 0; q < 4; q++) begin
        if (push_ok && (bus.push_id == 2'(q))) begin
          wr_ptr[q] <= wr_ptr[q] + 1'b1;
        end
        if (pop_ok && (bus.pop_id == 2'(q))) begin
          rd_ptr[q] <= rd_ptr[q] + 1'b1;
        end
        case ({push_ok && (bus.push_id == 2'(q)), pop_ok && (bus.pop_id == 2'(q))})
          2'b10:   count[q] <= count[q] + 1'b1;
          2'b01:   count[q] <= count[q] - 1'b1;
          default: count[q] <= count[q];
        endcase
      end
      if (pop_ok) begin
        data_out_q <= mem[bus.pop_id][rd_ptr[bus.pop_id]];
      end
      valid_q <= pop_ok;
      error_q <= (bus.push && !push_ok) || (bus.read && !pop_ok);
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid       = valid_q;
  assign bus.error       = error_q;
  assign bus.empty       = empty_c;
  assign bus.full        = full_c;
  assign bus.almost_full = af_c;
endmodule
